// File: rtl/hct_pkg.sv
// Shared constants and decode helper for the 74HCT154-style 4-to-16 decoder.
`timescale 1ns/1ps
package hct_pkg;

    localparam logic [15:0] DEC_ALL_OFF = 16'hFFFF;

    function automatic logic [15:0] onehot_low(input logic [3:0] a);
        return ~(16'h0001 << a);
    endfunction

endpackage

// File: rtl/hct_74154_dec4to16_core.sv
// Zero-delay enable and 4-to-16 active-low decode.
`timescale 1ns/1ps
module dec4to16_core
    import hct_pkg::*;
(
    input  logic        e0_n,
    input  logic        e1_n,
    input  logic [3:0]  a,
    output logic [15:0] y,
    output logic        en
);

    // Enable gating and one-hot-low decode
    always_comb begin
        en = ~e0_n & ~e1_n;
        if (en) begin
            y = onehot_low(a);
        end else begin
            y = DEC_ALL_OFF;
        end
    end

endmodule

// File: rtl/hct_74154.sv
// 74HCT154 decoder: delayed combinational Y plus optional registered copy.
`timescale 1ns/1ps
module hct_74154
    import hct_pkg::*;
#(
    parameter int PD_NS   = 13,
    parameter bit REG_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        _E0,
    input  logic        _E1,
    input  logic [3:0]  A,
    output logic [15:0] Y,
    output logic [15:0] Y_q,
    output logic        en_q
);

    logic [15:0] core_y_s;
    logic        core_en_s;
    logic [15:0] y_now_s;

    dec4to16_core u_core (
        .e0_n (_E0),
        .e1_n (_E1),
        .a    (A),
        .y    (core_y_s),
        .en   (core_en_s)
    );

    // Disable dominates unknowns; an enabled decode of an unknown yields all X
    always_comb begin
        if ((_E0 | _E1) === 1'b1) begin
            y_now_s = DEC_ALL_OFF;
        end else if ((^{_E0, _E1, A}) === 1'bx) begin
            y_now_s = {16{1'bx}};
        end else begin
            y_now_s = core_y_s;
        end
    end

    // Inertial propagation delay: pulses shorter than PD_NS never reach Y
    assign #(PD_NS) Y = y_now_s;

    generate
        if (REG_OUT) begin : g_reg
            logic [15:0] y_q_r;
            logic        en_q_r;

            // Registered copy of Y and the enable flag for synchronous consumers
            always_ff @(posedge clk) begin
                if (reset) begin
                    y_q_r  <= DEC_ALL_OFF;
                    en_q_r <= 1'b0;
                end else begin
                    y_q_r  <= Y;
                    en_q_r <= core_en_s;
                end
            end

            assign Y_q  = y_q_r;
            assign en_q = en_q_r;
        end else begin : g_noreg
            assign Y_q  = DEC_ALL_OFF;
            assign en_q = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_hct_74154.sv
// Self-checking bench for hct_74154: directed corner cases plus randomized model checks.
`timescale 1ns/1ps
module tb_hct_74154;

    localparam int PD_NS = 13;

    logic        clk;
    logic        reset;
    logic        e0_n;
    logic        e1_n;
    logic [3:0]  a;
    logic [15:0] y;
    logic [15:0] y_q;
    logic        en_q;

    int total;
    int bad;

    hct_74154 #(.PD_NS(PD_NS), .REG_OUT(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        ._E0   (e0_n),
        ._E1   (e1_n),
        .A     (a),
        .Y     (y),
        .Y_q   (y_q),
        .en_q  (en_q)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: output n is low only when both enables are low and the address equals n
    function automatic logic [15:0] model_y(input logic e0, input logic e1, input int addr);
        logic [15:0] r;
        for (int n = 0; n < 16; n++) begin
            r[n] = !((e0 == 1'b0) && (e1 == 1'b0) && (addr == n));
        end
        return r;
    endfunction

    function automatic int low_count(input logic [15:0] v);
        int c;
        c = 0;
        for (int n = 0; n < 16; n++) begin
            if (v[n] == 1'b0) c = c + 1;
        end
        return c;
    endfunction

    initial begin
        logic        r_e0;
        logic        r_e1;
        logic        r_rst;
        logic [3:0]  r_a;
        logic [15:0] prev;
        total = 0;
        bad   = 0;
        reset = 1'b1;

        // 1: disabled, address undriven
        e0_n = 1'b1;
        e1_n = 1'b1;
        #20;
        check("disabled_a_undriven", y, 16'hFFFF);

        // 2: single enable active
        e0_n = 1'b0; e1_n = 1'b1; a = 4'd3;
        #20;
        check("only_e0_low", y, 16'hFFFF);
        e0_n = 1'b1; e1_n = 1'b0;
        #20;
        check("only_e1_low", y, 16'hFFFF);

        // 3: directed decodes
        e0_n = 1'b0; e1_n = 1'b0;
        a = 4'd0; #20; check("a0", y, 16'hFFFE);
        a = 4'd1; #20; check("a1", y, 16'hFFFD);
        a = 4'd15; #20; check("a15", y, 16'h7FFF);

        // 4: sweep with delay-edge checks
        for (int i = 0; i < 16; i++) begin
            prev = y;
            a = 4'(i);
            #(PD_NS - 1);
            check("sweep_hold_old", y, prev);
            #2;
            check("sweep_new", y, model_y(1'b0, 1'b0, i));
            check("sweep_one_low", 16'(low_count(y)), 16'd1);
            check("sweep_low_bit", {15'd0, y[i]}, 16'd0);
            #(20 - PD_NS - 1);
        end

        // Randomized combinational checks
        for (int i = 0; i < 40; i++) begin
            r_e0 = 1'($urandom_range(0, 1));
            r_e1 = 1'($urandom_range(0, 1));
            r_a  = 4'($urandom_range(0, 15));
            e0_n = r_e0; e1_n = r_e1; a = r_a;
            #20;
            check("rand_comb", y, model_y(r_e0, r_e1, int'(r_a)));
        end

        // 5: clocked stage, reset held for two edges
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_yq", y_q, 16'hFFFF);
        check("reset_enq", {15'd0, en_q}, 16'd0);
        reset = 1'b0; e0_n = 1'b0; e1_n = 1'b0; a = 4'd5;
        @(negedge clk);
        check("a5_yq", y_q, 16'hFFDF);
        check("a5_enq", {15'd0, en_q}, 16'd1);

        // 6: mid-run reset clears the register but not Y
        reset = 1'b1;
        @(negedge clk);
        check("midreset_yq", y_q, 16'hFFFF);
        check("midreset_enq", {15'd0, en_q}, 16'd0);
        check("midreset_y", y, 16'hFFDF);
        reset = 1'b0;
        @(negedge clk);
        check("resume_yq", y_q, 16'hFFDF);
        check("resume_enq", {15'd0, en_q}, 16'd1);

        // Randomized clocked checks against the reference
        for (int i = 0; i < 60; i++) begin
            r_e0  = 1'($urandom_range(0, 1));
            r_e1  = 1'($urandom_range(0, 1));
            r_a   = 4'($urandom_range(0, 15));
            r_rst = ($urandom_range(0, 7) == 0);
            e0_n = r_e0; e1_n = r_e1; a = r_a; reset = r_rst;
            @(negedge clk);
            check("rand_yq", y_q, r_rst ? 16'hFFFF : model_y(r_e0, r_e1, int'(r_a)));
            check("rand_enq", {15'd0, en_q}, {15'd0, (!r_rst && !r_e0 && !r_e1)});
        end
        reset = 1'b0;

        // Enabled with an unknown address (only observable on a four-state simulator)
        e0_n = 1'b0; e1_n = 1'b0;
        a = 4'bxxxx;
        #20;
        if ($isunknown(a)) begin
            check("a_unknown", y, 16'hxxxx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
